alu_operand_stage: RTL
======================

Name: alu_operand_stage

Overview:
- ID/EX pipeline stage that sits directly upstream of the 64-bit ALU.
- Accepts one decoded instruction per handshake and derives the 4-bit aluControl code from aluOp/funct fields.
- Selects the register or immediate operand and resolves data hazards by forwarding.
- Registers X, Y and aluControl so they drive the ALU inputs directly.
- Valid/ready handshake on both sides; a synchronous flush for branch redirects.

Parameters:
- XLEN, 64, operand/result width.
- REG_IDX_W, 5, register index width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- flush  in  1  discard the held entry and any accepted input this cycle.
- in_valid  in  1  decode presents an instruction.
- in_ready  out  1  stage can accept.
- in_rs1_data  in  XLEN  register-file rs1 value.
- in_rs2_data  in  XLEN  register-file rs2 value.
- in_imm  in  XLEN  sign-extended immediate.
- in_alu_src  in  1  1: Y=imm; 0: Y=rs2.
- in_alu_op  in  2  00 mem, 01 branch, 10 R/I arithmetic.
- in_funct3  in  3  instruction funct3.
- in_funct7b5  in  1  instruction bit 30.
- in_rs1, in_rs2, in_rd  in  REG_IDX_W  register indices.
- in_reg_write  in  1  instruction writes rd.
- exm_reg_write, exm_rd, exm_data  in  1/REG_IDX_W/XLEN  EX/MEM forward bus.
- wb_reg_write, wb_rd, wb_data  in  1/REG_IDX_W/XLEN  MEM/WB forward bus.
- out_valid  out  1  ALU operands valid.
- out_ready  in  1  downstream consumes.
- X, Y  out  XLEN  ALU operands.
- aluControl  out  4  ALU function: 0 AND, 1 OR, 2 ADD, 6 SUB, 15 illegal.
- out_rs2_data  out  XLEN  store data, forwarded.
- out_rd  out  REG_IDX_W  destination index.
- out_reg_write  out  1  destination write enable.
- illegal_op  out  1  decode produced aluControl=15.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n. Under reset all outputs are 0, out_valid=0 and aluControl=4'd2; after rst_n deasserts, in_ready=1.
- Single-entry register: in_ready = !out_valid || out_ready. Transfer on in_valid && in_ready. Latency is 1 cycle, input accept to out_valid. Back-to-back transfers sustain full throughput.
- Output stability: the outputs are held stable while out_valid && !out_ready, except for the forwarding snoop below.
- aluControl decode:
  - alu_op=00 -> 2.
  - alu_op=01 -> 6.
  - alu_op=10, funct3 000 -> 6 if funct7b5 && !alu_src, else 2.
  - alu_op=10, funct3 111 -> 0.
  - alu_op=10, funct3 110 -> 1.
  - Any other combination -> 15 with illegal_op=1. The instruction still flows; out_reg_write is forced to 0.
- Operand capture: X = forwarded rs1. Y = in_imm if alu_src, else forwarded rs2. out_rs2_data = forwarded rs2 regardless of alu_src.
- Forwarding (at capture):
  - Source index 0 is never forwarded and always reads 0 for X, Y and out_rs2_data.
  - EX/MEM matches have priority over MEM/WB; if neither bus matches, the register-file value is used.
- Snoop while held (out_valid && !out_ready): if wb_reg_write && wb_rd!=0 && wb_rd equals the held rs1 (or rs2), the held X (or out_rs2_data, and Y when alu_src=0) is updated with wb_data next cycle. Held rs1/rs2 indices are kept internally.
- flush: next cycle out_valid=0 and out_reg_write=0. flush overrides a simultaneous accept, so the input is dropped. in_ready behaves normally during flush.
- Reset mid-stall drops the held entry.

Optional Feature:
- Macro: ALU_FWD_EN.
- Defined: forwarding and held-entry snoop as above.
- Undefined: operands are taken raw from in_rs1_data/in_rs2_data, with x0 still forced to 0. No snoop. The exm_*/wb_* inputs are unused. The hazard stall is then owned by the decode stage.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with in_valid=1 -> out_valid=0, aluControl=2, X=Y=0; in_ready=1 after release.
- R-type sub: alu_op=10, funct3=000, funct7b5=1, alu_src=0, rs1=5, rs2=3 -> next cycle aluControl=6, X=5, Y=3, out_valid=1. Repeat with alu_src=1, imm=-1 -> aluControl=2, Y=64'hFFFF_FFFF_FFFF_FFFF.
- Forward priority: rs1=x7; exm_rd=7 with data 0xAA; wb_rd=7 with data 0xBB -> X=0xAA. Same with rs1=x0 -> X=0.
- Stall and snoop: out_ready=0 with a held entry (rs2=x9, alu_src=0), then wb write x9=0x1234 -> Y=out_rs2_data=0x1234; in_ready=0 until out_ready=1.
- Flush: flush=1 in the same cycle as in_valid=1 with a held entry -> next cycle out_valid=0 and no entry accepted.
- Illegal decode: alu_op=10, funct3=001 -> aluControl=15, illegal_op=1, out_reg_write=0.

Source files
------------

// File: rtl/alu_operand_stage_if.sv
// Bundle of ID/EX handshake, operand, forwarding and ALU-side signals for alu_operand_stage.
// slave: the stage itself; master: the decode/ALU environment driving it.
interface alu_operand_stage_if #(
  parameter int XLEN      = 64,
  parameter int REG_IDX_W = 5
);
  logic                 flush;
  logic                 in_valid;
  logic                 in_ready;
  logic [XLEN-1:0]      in_rs1_data;
  logic [XLEN-1:0]      in_rs2_data;
  logic [XLEN-1:0]      in_imm;
  logic                 in_alu_src;
  logic [1:0]           in_alu_op;
  logic [2:0]           in_funct3;
  logic                 in_funct7b5;
  logic [REG_IDX_W-1:0] in_rs1;
  logic [REG_IDX_W-1:0] in_rs2;
  logic [REG_IDX_W-1:0] in_rd;
  logic                 in_reg_write;
  logic                 exm_reg_write;
  logic [REG_IDX_W-1:0] exm_rd;
  logic [XLEN-1:0]      exm_data;
  logic                 wb_reg_write;
  logic [REG_IDX_W-1:0] wb_rd;
  logic [XLEN-1:0]      wb_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [XLEN-1:0]      X;
  logic [XLEN-1:0]      Y;
  logic [3:0]           aluControl;
  logic [XLEN-1:0]      out_rs2_data;
  logic [REG_IDX_W-1:0] out_rd;
  logic                 out_reg_write;
  logic                 illegal_op;

  modport slave (
    input  flush, in_valid, in_rs1_data, in_rs2_data, in_imm, in_alu_src, in_alu_op,
           in_funct3, in_funct7b5, in_rs1, in_rs2, in_rd, in_reg_write,
           exm_reg_write, exm_rd, exm_data, wb_reg_write, wb_rd, wb_data, out_ready,
    output in_ready, out_valid, X, Y, aluControl, out_rs2_data, out_rd, out_reg_write,
           illegal_op
  );

  modport master (
    output flush, in_valid, in_rs1_data, in_rs2_data, in_imm, in_alu_src, in_alu_op,
           in_funct3, in_funct7b5, in_rs1, in_rs2, in_rd, in_reg_write,
           exm_reg_write, exm_rd, exm_data, wb_reg_write, wb_rd, wb_data, out_ready,
    input  in_ready, out_valid, X, Y, aluControl, out_rs2_data, out_rd, out_reg_write,
           illegal_op
  );
endinterface

// File: rtl/alu_operand_stage.sv
// ID/EX stage feeding the 64-bit ALU: aluControl decode, operand select, registered outputs.
// Define ALU_FWD_EN to enable EX/MEM + MEM/WB forwarding and the held-entry WB snoop.
module alu_operand_stage #(
  parameter int XLEN      = 64,
  parameter int REG_IDX_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_operand_stage_if.slave bus
);
  typedef enum logic [3:0] {
    ALU_AND = 4'd0,
    ALU_OR  = 4'd1,
    ALU_ADD = 4'd2,
    ALU_SUB = 4'd6,
    ALU_ILL = 4'd15
  } alu_ctl_e;

  logic                 r_valid;
  logic [XLEN-1:0]      r_x;
  logic [XLEN-1:0]      r_y;
  logic [XLEN-1:0]      r_rs2_data;
  alu_ctl_e             r_ctl;
  logic [REG_IDX_W-1:0] r_rd;
  logic                 r_reg_write;
  logic                 r_illegal;

  alu_ctl_e             w_ctl;
  logic                 w_illegal;
  logic                 w_accept;
  logic [XLEN-1:0]      w_rs1_val;
  logic [XLEN-1:0]      w_rs2_val;

  assign bus.in_ready = !r_valid || bus.out_ready;
  assign w_accept     = bus.in_valid && bus.in_ready && !bus.flush;

  always_comb begin
    w_ctl = ALU_ILL;
    case (bus.in_alu_op)
      2'b00: w_ctl = ALU_ADD;
      2'b01: w_ctl = ALU_SUB;
      2'b10: begin
        case (bus.in_funct3)
          3'b000:  w_ctl = (bus.in_funct7b5 && !bus.in_alu_src) ? ALU_SUB : ALU_ADD;
          3'b111:  w_ctl = ALU_AND;
          3'b110:  w_ctl = ALU_OR;
          default: w_ctl = ALU_ILL;
        endcase
      end
      default: w_ctl = ALU_ILL;
    endcase
  end

  assign w_illegal = (w_ctl == ALU_ILL);

`ifdef ALU_FWD_EN
  logic [REG_IDX_W-1:0] r_rs1;
  logic [REG_IDX_W-1:0] r_rs2;
  logic                 r_alu_src;
  logic                 w_snoop_rs1;
  logic                 w_snoop_rs2;

  // EX/MEM wins over MEM/WB; x0 override is applied last so it beats both buses.
  always_comb begin
    w_rs1_val = bus.in_rs1_data;
    w_rs2_val = bus.in_rs2_data;
    if (bus.exm_reg_write && bus.exm_rd == bus.in_rs1)     w_rs1_val = bus.exm_data;
    else if (bus.wb_reg_write && bus.wb_rd == bus.in_rs1)  w_rs1_val = bus.wb_data;
    if (bus.exm_reg_write && bus.exm_rd == bus.in_rs2)     w_rs2_val = bus.exm_data;
    else if (bus.wb_reg_write && bus.wb_rd == bus.in_rs2)  w_rs2_val = bus.wb_data;
    if (bus.in_rs1 == '0) w_rs1_val = '0;
    if (bus.in_rs2 == '0) w_rs2_val = '0;
  end

  assign w_snoop_rs1 = bus.wb_reg_write && (bus.wb_rd != '0) && (bus.wb_rd == r_rs1);
  assign w_snoop_rs2 = bus.wb_reg_write && (bus.wb_rd != '0) && (bus.wb_rd == r_rs2);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rs1     <= '0;
      r_rs2     <= '0;
      r_alu_src <= 1'b0;
    end else if (w_accept) begin
      r_rs1     <= bus.in_rs1;
      r_rs2     <= bus.in_rs2;
      r_alu_src <= bus.in_alu_src;
    end
  end
`else
  logic w_unused_fwd;
  assign w_unused_fwd = ^{bus.exm_reg_write, bus.exm_rd, bus.exm_data,
                          bus.wb_reg_write, bus.wb_rd, bus.wb_data};

  always_comb begin
    w_rs1_val = (bus.in_rs1 == '0) ? '0 : bus.in_rs1_data;
    w_rs2_val = (bus.in_rs2 == '0) ? '0 : bus.in_rs2_data;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid     <= 1'b0;
      r_x         <= '0;
      r_y         <= '0;
      r_rs2_data  <= '0;
      r_ctl       <= ALU_ADD;
      r_rd        <= '0;
      r_reg_write <= 1'b0;
      r_illegal   <= 1'b0;
    end else if (bus.flush) begin
      r_valid     <= 1'b0;
      r_reg_write <= 1'b0;
    end else if (w_accept) begin
      r_valid     <= 1'b1;
      r_x         <= w_rs1_val;
      r_y         <= bus.in_alu_src ? bus.in_imm : w_rs2_val;
      r_rs2_data  <= w_rs2_val;
      r_ctl       <= w_ctl;
      r_rd        <= bus.in_rd;
      r_reg_write <= bus.in_reg_write && !w_illegal;
      r_illegal   <= w_illegal;
    end else if (bus.out_ready) begin
      r_valid <= 1'b0;
`ifdef ALU_FWD_EN
    end else if (r_valid) begin
      // Held entry picks up a late write-back so the ALU never sees a stale operand.
      if (w_snoop_rs1) r_x <= bus.wb_data;
      if (w_snoop_rs2) begin
        r_rs2_data <= bus.wb_data;
        if (!r_alu_src) r_y <= bus.wb_data;
      end
`endif
    end
  end

  assign bus.out_valid     = r_valid;
  assign bus.X             = r_x;
  assign bus.Y             = r_y;
  assign bus.aluControl    = r_ctl;
  assign bus.out_rs2_data  = r_rs2_data;
  assign bus.out_rd        = r_rd;
  assign bus.out_reg_write = r_reg_write;
  assign bus.illegal_op    = r_illegal;
endmodule
